// File: rtl/riscv_mem_responder_if.sv
// Core <-> memory bus: instruction fetch port plus the single data port.
// Latency: n/a (signal bundle only).
// Backpressure: none; the responder accepts every request in the cycle it appears.
interface riscv_mem_responder_if;
  logic [31:0] PC;
  logic [31:0] instr;
  logic [31:0] dAddress;
  logic [31:0] dWriteData;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] dReadData;

  // Core side drives addresses and strobes, receives registered data.
  modport master (
    output PC, dAddress, dWriteData, MemRead, MemWrite,
    input  instr, dReadData
  );

  // Memory side answers fetches and data accesses.
  modport slave (
    input  PC, dAddress, dWriteData, MemRead, MemWrite,
    output instr, dReadData
  );
endinterface

// File: rtl/riscv_mem_responder.sv
// Word-addressed text/data memory for the multicycle RISC-V core, with program-load port, sticky err and counters.
// Latency: 1 cycle for fetch and load (registered outputs); stores commit at the edge they are presented.
// Backpressure: none; every request is served or flagged in its own cycle, there is no stall path.
module riscv_mem_responder #(
  parameter logic [31:0] TEXT_BASE  = 32'h00400000,
  parameter logic [31:0] DATA_BASE  = 32'h10010000,
  parameter int          TEXT_WORDS = 256,
  parameter int          DATA_WORDS = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  riscv_mem_responder_if.slave  bus,
  input  logic                  load_en,
  input  logic [31:0]           load_addr,
  input  logic [31:0]           load_data,
  output logic                  err,
  output logic [15:0]           rd_count,
  output logic [15:0]           wr_count
);

  localparam int          TW        = $clog2(TEXT_WORDS);
  localparam int          DW        = $clog2(DATA_WORDS);
  localparam logic [31:0] TEXT_SPAN = 32'(4 * TEXT_WORDS);
  localparam logic [31:0] DATA_SPAN = 32'(4 * DATA_WORDS);
  localparam logic [31:0] NOP       = 32'h00000013;

  // Arrays are deliberately never reset so a preload survives rst.
  logic [31:0] text_mem [TEXT_WORDS];
  logic [31:0] data_mem [DATA_WORDS];

  logic [31:0] instr_q, instr_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [15:0] rd_count_q, rd_count_d;
  logic [15:0] wr_count_q, wr_count_d;

  // Address decode: in-range and word-aligned, otherwise an access error.
  logic          fetch_ok, data_ok, load_ok;
  logic [TW-1:0] fetch_idx, load_idx;
  logic [DW-1:0] data_idx;

  assign fetch_ok  = (bus.PC[1:0] == 2'b00) && (bus.PC >= TEXT_BASE) &&
                     ((bus.PC - TEXT_BASE) < TEXT_SPAN);
  assign fetch_idx = TW'((bus.PC - TEXT_BASE) >> 2);

  assign data_ok   = (bus.dAddress[1:0] == 2'b00) && (bus.dAddress >= DATA_BASE) &&
                     ((bus.dAddress - DATA_BASE) < DATA_SPAN);
  assign data_idx  = DW'((bus.dAddress - DATA_BASE) >> 2);

  assign load_ok   = (load_addr[1:0] == 2'b00) && (load_addr >= TEXT_BASE) &&
                     ((load_addr - TEXT_BASE) < TEXT_SPAN);
  assign load_idx  = TW'((load_addr - TEXT_BASE) >> 2);

  // Request classification; simultaneous read+write is rejected outright.
  logic rd_req, wr_req, both_req;
  logic wr_acc, text_wr;
  logic access_err, load_err;

  assign rd_req     = bus.MemRead  & ~bus.MemWrite;
  assign wr_req     = bus.MemWrite & ~bus.MemRead;
  assign both_req   = bus.MemRead  &  bus.MemWrite;
  assign wr_acc     = ~rst & wr_req & data_ok;
  assign text_wr    = load_en & load_ok;
  assign access_err = ~fetch_ok | (rd_req & ~data_ok) | (wr_req & ~data_ok) | both_req;
  assign load_err   = load_en & ~load_ok;

  // Next-state for registered responses, sticky error and saturating counters.
  always_comb begin
    instr_d    = fetch_ok ? text_mem[fetch_idx] : NOP;
    rdata_d    = rdata_q;
    err_d      = err_q | access_err | load_err;
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;

    if (rd_req) begin
      rdata_d = data_ok ? data_mem[data_idx] : 32'h0;
    end
    if (rd_req && data_ok && (rd_count_q != 16'hFFFF)) begin
      rd_count_d = rd_count_q + 16'd1;
    end
    if (wr_req && data_ok && (wr_count_q != 16'hFFFF)) begin
      wr_count_d = wr_count_q + 16'd1;
    end

    // Reset suppresses core-side checks but a bad program-load address still flags.
    if (rst) begin
      instr_d    = NOP;
      rdata_d    = 32'h0;
      err_d      = load_err;
      rd_count_d = 16'h0;
      wr_count_d = 16'h0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    instr_q    <= instr_d;
    rdata_q    <= rdata_d;
    err_q      <= err_d;
    rd_count_q <= rd_count_d;
    wr_count_q <= wr_count_d;
  end

  // Array writes; reads above see the pre-edge contents (read-first).
  always_ff @(posedge clk) begin
    if (text_wr) begin
      text_mem[load_idx] <= load_data;
    end
    if (wr_acc) begin
      data_mem[data_idx] <= bus.dWriteData;
    end
  end

  assign bus.instr     = instr_q;
  assign bus.dReadData = rdata_q;
  assign err           = err_q;
  assign rd_count      = rd_count_q;
  assign wr_count      = wr_count_q;

endmodule

// File: tb/tb_riscv_mem_responder.sv
// Self-checking bench for riscv_mem_responder: vector table through a scoreboard queue plus hand sequences.
// Latency: checks one cycle after each applied vector.
// Backpressure: n/a.
module tb_riscv_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_en;
  logic [31:0] load_addr;
  logic [31:0] load_data;
  logic        err;
  logic [15:0] rd_count;
  logic [15:0] wr_count;

  riscv_mem_responder_if bus ();

  riscv_mem_responder dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .err       (err),
    .rd_count  (rd_count),
    .wr_count  (wr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rd;
    logic        wr;
    logic [31:0] exp_instr;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [15:0] exp_rc;
    logic [15:0] exp_wc;
  } vec_t;

  vec_t vecs [11];
  vec_t sb_q [$];

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bus(input logic [31:0] pc, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic rd, input logic wr);
    bus.PC         = pc;
    bus.dAddress   = addr;
    bus.dWriteData = wdata;
    bus.MemRead    = rd;
    bus.MemWrite   = wr;
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    tick();
    load_en   = 1'b0;
  endtask

  initial begin
    vec_t e;
    // pc, addr, wdata, rd, wr, instr, rdata, err, rc, wc
    vecs[0]  = '{32'h00400000, 32'h0,        32'h0,        1'b0, 1'b0, 32'h00500093, 32'h0,        1'b0, 16'd0, 16'd0};
    vecs[1]  = '{32'h00400004, 32'h0,        32'h0,        1'b0, 1'b0, 32'h00000013, 32'h0,        1'b0, 16'd0, 16'd0};
    vecs[2]  = '{32'h00400008, 32'h10010008, 32'hDEADBEEF, 1'b0, 1'b1, 32'hABCDE123, 32'h0,        1'b0, 16'd0, 16'd1};
    vecs[3]  = '{32'h00400000, 32'h10010008, 32'h0,        1'b1, 1'b0, 32'h00500093, 32'hDEADBEEF, 1'b0, 16'd1, 16'd1};
    vecs[4]  = '{32'h00400000, 32'h10010000, 32'h11112222, 1'b0, 1'b1, 32'h00500093, 32'hDEADBEEF, 1'b0, 16'd1, 16'd2};
    vecs[5]  = '{32'h00400000, 32'h10010000, 32'h0,        1'b1, 1'b0, 32'h00500093, 32'h11112222, 1'b0, 16'd2, 16'd2};
    vecs[6]  = '{32'h00400000, 32'h10010000, 32'h99999999, 1'b1, 1'b1, 32'h00500093, 32'h11112222, 1'b1, 16'd2, 16'd2};
    vecs[7]  = '{32'h00400000, 32'h10010000, 32'h0,        1'b1, 1'b0, 32'h00500093, 32'h11112222, 1'b1, 16'd3, 16'd2};
    vecs[8]  = '{32'h00400000, 32'h10010002, 32'h0,        1'b1, 1'b0, 32'h00500093, 32'h0,        1'b1, 16'd3, 16'd2};
    vecs[9]  = '{32'h00400000, 32'h00400000, 32'h0,        1'b0, 1'b1, 32'h00500093, 32'h0,        1'b1, 16'd3, 16'd2};
    vecs[10] = '{32'h00400000, 32'h0,        32'h0,        1'b0, 1'b0, 32'h00500093, 32'h0,        1'b1, 16'd3, 16'd2};

    // Preload program under reset; out-of-range PC must not raise err while rst is high.
    rst = 1'b1;
    load_en = 1'b0; load_addr = 32'h0; load_data = 32'h0;
    set_bus(32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    preload(32'h00400000, 32'h00500093);
    preload(32'h00400004, 32'h00000013);
    preload(32'h00400008, 32'hABCDE123);
    chk("reset_instr", bus.instr, 32'h00000013);
    chk("reset_rdata", bus.dReadData, 32'h0);
    chk("reset_err",   {31'h0, err}, 32'h0);
    chk("reset_rc",    {16'h0, rd_count}, 32'h0);
    chk("reset_wc",    {16'h0, wr_count}, 32'h0);

    // Vector table through the scoreboard.
    rst = 1'b0;
    for (int i = 0; i < 11; i++) begin
      set_bus(vecs[i].pc, vecs[i].addr, vecs[i].wdata, vecs[i].rd, vecs[i].wr);
      sb_q.push_back(vecs[i]);
      tick();
      e = sb_q.pop_front();
      chk($sformatf("v%0d_instr", i), bus.instr, e.exp_instr);
      chk($sformatf("v%0d_rdata", i), bus.dReadData, e.exp_rdata);
      chk($sformatf("v%0d_err", i),   {31'h0, err}, {31'h0, e.exp_err});
      chk($sformatf("v%0d_rc", i),    {16'h0, rd_count}, {16'h0, e.exp_rc});
      chk($sformatf("v%0d_wc", i),    {16'h0, wr_count}, {16'h0, e.exp_wc});
    end
    set_bus(32'h00400000, 32'h0, 32'h0, 1'b0, 1'b0);

    // Only rst clears err.
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_clr_err", {31'h0, err}, 32'h0);
    chk("rst_clr_rc",  {16'h0, rd_count}, 32'h0);
    chk("rst_clr_wc",  {16'h0, wr_count}, 32'h0);

    // Out-of-range fetch.
    bus.PC = 32'h0; tick();
    chk("oor_instr", bus.instr, 32'h00000013);
    chk("oor_err",   {31'h0, err}, 32'h1);

    // Read-first: load_en to the fetched word shows old word, new one a cycle later.
    rst = 1'b1; bus.PC = 32'h00400000; tick(); rst = 1'b0;
    bus.PC = 32'h00400004;
    load_en = 1'b1; load_addr = 32'h00400004; load_data = 32'hCAFEF00D;
    tick();
    load_en = 1'b0;
    chk("rf_old", bus.instr, 32'h00000013);
    chk("rf_err", {31'h0, err}, 32'h0);
    tick();
    chk("rf_new", bus.instr, 32'hCAFEF00D);

    // Bad load address flags even under rst; good load under rst is written.
    rst = 1'b1;
    preload(32'h00000000, 32'h12345678);
    chk("ld_bad_err", {31'h0, err}, 32'h1);
    preload(32'h0040000C, 32'h55AA55AA);
    chk("ld_good_err", {31'h0, err}, 32'h0);
    rst = 1'b0;
    bus.PC = 32'h0040000C; tick();
    chk("ld_good_instr", bus.instr, 32'h55AA55AA);
    chk("ld_good_err2", {31'h0, err}, 32'h0);
    bus.PC = 32'h00400000;

    // Counters: rst mid-sequence drops the concurrent store and zeroes counters.
    for (int i = 0; i < 100; i++) begin
      set_bus(32'h00400000, 32'h10010010, 32'(i), 1'b0, 1'b1);
      tick();
    end
    chk("wc_100", {16'h0, wr_count}, 32'd100);
    rst = 1'b1;
    set_bus(32'h00400000, 32'h10010008, 32'h12345678, 1'b0, 1'b1);
    tick();
    rst = 1'b0;
    chk("mid_rst_wc",  {16'h0, wr_count}, 32'h0);
    chk("mid_rst_err", {31'h0, err}, 32'h0);
    for (int i = 0; i < 65540; i++) begin
      set_bus(32'h00400000, 32'h10010010, 32'(i), 1'b0, 1'b1);
      tick();
    end
    chk("wc_sat", {16'h0, wr_count}, 32'h0000FFFF);
    chk("sat_err", {31'h0, err}, 32'h0);
    set_bus(32'h00400000, 32'h10010010, 32'h0, 1'b1, 1'b0);
    tick();
    chk("last_store", bus.dReadData, 32'd65539);
    chk("rc_after", {16'h0, rd_count}, 32'd1);
    set_bus(32'h00400000, 32'h10010008, 32'h0, 1'b1, 1'b0);
    tick();
    chk("preserved", bus.dReadData, 32'hDEADBEEF);
    set_bus(32'h00400000, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    chk("rdata_hold", bus.dReadData, 32'hDEADBEEF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
